// File: rtl/logic_gate_checker.sv
// Self-checking stage for the two-input AND/OR/XOR gate unit.
// Latency: status updates one cycle after the sampling edge; done/pass land with the last update.
// Backpressure: none; accepts a sample on every cycle and silently ignores strobes outside a run.
module logic_gate_checker #(
    parameter int CNT_W       = 8,
    parameter int MAX_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_en,
    input  logic             a,
    input  logic             b,
    input  logic             op_and,
    input  logic             op_or,
    input  logic             op_xor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       coverage,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [4:0]       first_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

    state_t            state, state_nx;
    logic              pass_nx;
    logic [3:0]        cov_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CNT_W-1:0]  err_nx;
    logic [4:0]        fe_nx;
    logic [2:0]        expected;
    logic              mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pass         <= 1'b0;
            coverage     <= '0;
            sample_count <= '0;
            err_count    <= '0;
            first_err    <= '0;
        end else begin
            state        <= state_nx;
            pass         <= pass_nx;
            coverage     <= cov_nx;
            sample_count <= cnt_nx;
            err_count    <= err_nx;
            first_err    <= fe_nx;
        end
    end

    assign expected = {a & b, a | b, a ^ b};
    assign mismatch = (expected != {op_and, op_or, op_xor});

    always_comb begin
        state_nx = state;
        pass_nx  = pass;
        cov_nx   = coverage;
        cnt_nx   = sample_count;
        err_nx   = err_count;
        fe_nx    = first_err;

        // start wins over any simultaneous sample, which is dropped
        if (start) begin
            state_nx = S_RUN;
            pass_nx  = 1'b0;
            cov_nx   = '0;
            cnt_nx   = '0;
            err_nx   = '0;
            fe_nx    = '0;
        end else if (state == S_RUN && sample_en) begin
            cov_nx = coverage | (4'b0001 << {a, b});
            cnt_nx = sample_count + 1'b1;
            if (mismatch) begin
                if (err_count != '1) begin
                    err_nx = err_count + 1'b1;
                end
                if (err_count == '0) begin
                    fe_nx = {a, b, op_and, op_or, op_xor};
                end
            end
            // full coverage or sample limit ends the run; pass is judged on the final values
            if (cov_nx == 4'hF || cnt_nx == MAX_CNT) begin
                state_nx = S_DONE;
                pass_nx  = (err_nx == '0) && (cov_nx == 4'hF);
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_logic_gate_checker.sv
// Bench for logic_gate_checker: directed vectors, expected results queued and checked by a monitor.
module tb_logic_gate_checker;

    logic       clk = 1'b0;
    logic       rst, start, sample_en, start2, sample_en2;
    logic       a, b, op_and, op_or, op_xor;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [3:0] coverage, coverage2;
    logic [7:0] sample_count, err_count;
    logic [1:0] sample_count2, err_count2;
    logic [4:0] first_err, first_err2;

    typedef struct {
        logic       done, pass, busy;
        logic [3:0] cov;
        logic [7:0] cnt, err;
        logic [4:0] fe;
        int         at;
    } rec_t;

    rec_t dq1[$], sq1[$], dq2[$], sq2[$];
    int   total = 0, bad = 0, cyc = 0;
    logic done1_prev = 1'b0, done2_prev = 1'b0;

    logic_gate_checker #(.CNT_W(8), .MAX_SAMPLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
        .a(a), .b(b), .op_and(op_and), .op_or(op_or), .op_xor(op_xor),
        .busy(busy), .done(done), .pass(pass), .coverage(coverage),
        .sample_count(sample_count), .err_count(err_count), .first_err(first_err)
    );

    logic_gate_checker #(.CNT_W(2), .MAX_SAMPLES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sample_en(sample_en2),
        .a(a), .b(b), .op_and(op_and), .op_or(op_or), .op_xor(op_xor),
        .busy(busy2), .done(done2), .pass(pass2), .coverage(coverage2),
        .sample_count(sample_count2), .err_count(err_count2), .first_err(first_err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic rec_t mk(input logic d, input logic p, input logic bz, input logic [3:0] cv,
                                input logic [7:0] cn, input logic [7:0] er, input logic [4:0] f);
        rec_t r;
        r.done = d; r.pass = p; r.busy = bz; r.cov = cv;
        r.cnt = cn; r.err = er; r.fe = f; r.at = cyc;
        return r;
    endfunction

    function automatic rec_t obs1();
        return mk(done, pass, busy, coverage, sample_count, err_count, first_err);
    endfunction

    function automatic rec_t obs2();
        return mk(done2, pass2, busy2, coverage2, {6'b0, sample_count2}, {6'b0, err_count2}, first_err2);
    endfunction

    task automatic cmp(input string tag, input rec_t e, input rec_t o);
        chk({tag, ".done"}, 32'(o.done), 32'(e.done));
        chk({tag, ".pass"}, 32'(o.pass), 32'(e.pass));
        chk({tag, ".busy"}, 32'(o.busy), 32'(e.busy));
        chk({tag, ".coverage"}, 32'(o.cov), 32'(e.cov));
        chk({tag, ".sample_count"}, 32'(o.cnt), 32'(e.cnt));
        chk({tag, ".err_count"}, 32'(o.err), 32'(e.err));
        chk({tag, ".first_err"}, 32'(o.fe), 32'(e.fe));
    endtask

    // Monitor: completion records pop on each rising done, snapshots pop on their stamped cycle
    always @(negedge clk) begin
        if (done && !done1_prev) begin
            if (dq1.size() == 0) chk("unexpected_done", 32'(done), 32'(0));
            else cmp("done_rec", dq1.pop_front(), obs1());
        end
        done1_prev = done;
        if (done2 && !done2_prev) begin
            if (dq2.size() == 0) chk("unexpected_done2", 32'(done2), 32'(0));
            else cmp("done_rec2", dq2.pop_front(), obs2());
        end
        done2_prev = done2;
        if (sq1.size() > 0 && sq1[0].at == cyc) cmp("snap", sq1.pop_front(), obs1());
        if (sq2.size() > 0 && sq2[0].at == cyc) cmp("snap2", sq2.pop_front(), obs2());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic ia, input logic ib, input logic ga, input logic go, input logic gx);
        a = ia; b = ib; op_and = ga; op_or = go; op_xor = gx;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic good(input logic ia, input logic ib);
        smp(ia, ib, ia & ib, ia | ib, ia ^ ib);
    endtask

    task automatic go1();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; sample_en = 1'b0; start2 = 1'b0; sample_en2 = 1'b0;
        a = 1'b0; b = 1'b0; op_and = 1'b0; op_or = 1'b0; op_xor = 1'b0;
        #2;
        cmp("reset", mk(0, 0, 0, 4'h0, 8'd0, 8'd0, 5'd0), obs1());
        cmp("reset2", mk(0, 0, 0, 4'h0, 8'd0, 8'd0, 5'd0), obs2());
        tick(); tick();
        rst = 1'b0;
        // sample in IDLE is ignored
        good(1, 1);
        sq1.push_back(mk(0, 0, 0, 4'h0, 8'd0, 8'd0, 5'd0));
        tick();

        // exhaustive clean run
        go1();
        sq1.push_back(mk(0, 0, 1, 4'h0, 8'd0, 8'd0, 5'd0));
        dq1.push_back(mk(1, 1, 0, 4'hF, 8'd4, 8'd0, 5'd0));
        good(0, 0); good(0, 1); good(1, 0); good(1, 1);
        tick();

        // injected fault: xor stuck low at (1,0)
        go1();
        dq1.push_back(mk(1, 0, 0, 4'hF, 8'd4, 8'd1, 5'b10010));
        good(0, 0); good(0, 1); smp(1, 0, 0, 1, 0); good(1, 1);
        tick();

        // timeout at the sample limit with partial coverage
        go1();
        dq1.push_back(mk(1, 0, 0, 4'b0011, 8'd16, 8'd0, 5'd0));
        for (int i = 0; i < 16; i++) good(0, i[0]);
        tick();

        // restart priority: simultaneous sample is discarded
        go1();
        good(0, 0); good(0, 1); good(1, 0);
        a = 1'b1; b = 1'b1; op_and = 1'b1; op_or = 1'b1; op_xor = 1'b0;
        start = 1'b1; sample_en = 1'b1;
        tick();
        start = 1'b0; sample_en = 1'b0;
        sq1.push_back(mk(0, 0, 1, 4'h0, 8'd0, 8'd0, 5'd0));
        dq1.push_back(mk(1, 1, 0, 4'hF, 8'd4, 8'd0, 5'd0));
        good(0, 0); good(0, 1); good(1, 0); good(1, 1);
        tick();

        // asynchronous reset mid-run
        go1();
        good(0, 0); smp(1, 1, 0, 0, 0);
        #3 rst = 1'b1;
        #1 cmp("async_rst", mk(0, 0, 0, 4'h0, 8'd0, 8'd0, 5'd0), obs1());
        #2 rst = 1'b0;
        tick();
        good(1, 1); good(0, 0);
        sq1.push_back(mk(0, 0, 0, 4'h0, 8'd0, 8'd0, 5'd0));
        go1();
        dq1.push_back(mk(1, 1, 0, 4'hF, 8'd4, 8'd0, 5'd0));
        good(1, 1); good(1, 0); good(0, 1); good(0, 0);
        tick();

        // narrow counters: three wrong samples, then strobes in DONE ignored
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        dq2.push_back(mk(1, 0, 0, 4'b0001, 8'd3, 8'd3, 5'b00100));
        a = 1'b0; b = 1'b0; op_and = 1'b1; op_or = 1'b0; op_xor = 1'b0;
        sample_en2 = 1'b1;
        repeat (3) tick();
        a = 1'b1; b = 1'b1; op_and = 1'b1; op_or = 1'b1; op_xor = 1'b0;
        repeat (2) tick();
        sample_en2 = 1'b0;
        sq2.push_back(mk(1, 0, 0, 4'b0001, 8'd3, 8'd3, 5'b00100));

        repeat (5) tick();
        while (dq1.size() > 0) begin void'(dq1.pop_front()); chk("missing_done", 32'(0), 32'(1)); end
        while (sq1.size() > 0) begin void'(sq1.pop_front()); chk("missing_snap", 32'(0), 32'(1)); end
        while (dq2.size() > 0) begin void'(dq2.pop_front()); chk("missing_done2", 32'(0), 32'(1)); end
        while (sq2.size() > 0) begin void'(sq2.pop_front()); chk("missing_snap2", 32'(0), 32'(1)); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
